// File: rtl/seq_adder.sv
// seq_adder: multi-cycle chunked adder/subtractor with valid/ready handshakes
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             overflow
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("seq_adder: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, nxt;
    logic [WIDTH-1:0]  ra, rb, acc, acc_nxt;
    logic              carry, rsub, last, cmsb;
    logic [CW-1:0]     cnt;
    logic [CHUNK-1:0]  ca, cb;
    logic [CHUNK:0]    cs;

    // Current chunk slice, its sum, and the carry into the chunk's top bit
    always_comb begin
        ca      = ra[cnt*CHUNK +: CHUNK];
        cb      = rb[cnt*CHUNK +: CHUNK];
        cs      = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
        last    = cnt == CW'(N - 1);
        cmsb    = ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1];
        acc_nxt = acc;
        acc_nxt[cnt*CHUNK +: CHUNK] = cs[CHUNK-1:0];
    end

    // Next-state and handshake decode
    always_comb begin
        nxt       = state;
        if (state == IDLE && in_valid)
            nxt = RUN;
        else if (state == RUN && last)
            nxt = DONE;
        else if (state == DONE && out_ready)
            nxt = IDLE;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // State register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nxt;
    end

    // Operand latch, chunk iteration and result registration on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            ra       <= '0;
            rb       <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            rsub     <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else if (in_ready && in_valid) begin
            ra    <= a;
            rb    <= sub ? ~b : b;
            carry <= cin ^ sub;
            rsub  <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= cs[CHUNK];
            cnt   <= last ? cnt : cnt + CW'(1);
            if (last) begin
                sum      <= {rsub ? ~cs[CHUNK] : cs[CHUNK], acc_nxt};
                overflow <= cmsb ^ cs[CHUNK];
            end
        end
    end
endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: self-checking bench for seq_adder in three configurations
module tb_seq_adder;
    logic clk, rst;
    logic       tiv[3], tor[3], tcin[3], tsub[3];
    logic [7:0] ta[3], tbv[3];
    logic       ir[3], ovl[3], ovf[3];
    logic [8:0] s8;
    logic [3:0] s31, s33;
    int checks = 0;
    int errors = 0;
    int wd[3] = '{8, 3, 3};
    int nn[3] = '{4, 3, 1};

    seq_adder #(.WIDTH(8), .CHUNK(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(tiv[0]), .in_ready(ir[0]),
        .a(ta[0]), .b(tbv[0]), .cin(tcin[0]), .sub(tsub[0]),
        .out_valid(ovl[0]), .out_ready(tor[0]), .sum(s8), .overflow(ovf[0]));
    seq_adder #(.WIDTH(3), .CHUNK(1)) u31 (
        .clk(clk), .rst(rst), .in_valid(tiv[1]), .in_ready(ir[1]),
        .a(ta[1][2:0]), .b(tbv[1][2:0]), .cin(tcin[1]), .sub(tsub[1]),
        .out_valid(ovl[1]), .out_ready(tor[1]), .sum(s31), .overflow(ovf[1]));
    seq_adder #(.WIDTH(3), .CHUNK(3)) u33 (
        .clk(clk), .rst(rst), .in_valid(tiv[2]), .in_ready(ir[2]),
        .a(ta[2][2:0]), .b(tbv[2][2:0]), .cin(tcin[2]), .sub(tsub[2]),
        .out_valid(ovl[2]), .out_ready(tor[2]), .sum(s33), .overflow(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gsum(int i);
        return i == 0 ? int'(s8) : i == 1 ? int'(s31) : int'(s33);
    endfunction

    // Reference: integer arithmetic on unsigned and signed views of the operands
    task automatic model(input int w, input int av, input int bv, input int ci, input int sb,
                         output int es, output int eo);
        int m, d, sa, sbb, r;
        m = (1 << w) - 1;
        if (sb == 0) begin
            es = av + bv + ci;
        end else begin
            d  = av - bv - ci;
            es = ((d < 0 ? 1 : 0) << w) | (d & m);
        end
        sa  = av >= (1 << (w - 1)) ? av - (1 << w) : av;
        sbb = bv >= (1 << (w - 1)) ? bv - (1 << w) : bv;
        r   = sb == 0 ? sa + sbb + ci : sa - sbb - ci;
        eo  = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input int i, input int av, input int bv, input int ci, input int sb,
                      input string tag);
        int es, eo, lat;
        model(wd[i], av, bv, ci, sb, es, eo);
        ta[i] = 8'(av); tbv[i] = 8'(bv); tcin[i] = 1'(ci); tsub[i] = 1'(sb); tiv[i] = 1'b1;
        check({tag, " in_ready"}, int'(ir[i]), 1);
        @(posedge clk); #1;
        tiv[i] = 1'b0;
        lat = 0;
        while (!ovl[i] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, nn[i]);
        check({tag, " sum"}, gsum(i), es);
        check({tag, " overflow"}, int'(ovf[i]), eo);
        tor[i] = 1'b1;
        @(posedge clk); #1;
        tor[i] = 1'b0;
    endtask

    initial begin
        int es, eo, lat;
        int acc_t[$];
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tiv[i] = 0; tor[i] = 0; tcin[i] = 0; tsub[i] = 0; ta[i] = 0; tbv[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset out_valid", int'(ovl[i]), 0);
            check("reset in_ready", int'(ir[i]), 1);
            check("reset sum", gsum(i), 0);
            check("reset overflow", int'(ovf[i]), 0);
        end
        rst = 1'b0;

        op(0, 'hFF, 'h01, 0, 0, "add ff+01");
        op(0, 'h7F, 'h01, 0, 0, "add 7f+01");
        op(0, 'h05, 'h07, 0, 1, "sub 05-07");
        op(0, 'h80, 'h01, 0, 1, "sub 80-01");
        op(0, 'h10, 'h0F, 1, 1, "sub 10-0f-1");

        ta[0] = 8'hA5; tbv[0] = 8'h3C; tcin[0] = 0; tsub[0] = 1; tiv[0] = 1;
        model(8, 'hA5, 'h3C, 0, 1, es, eo);
        @(posedge clk); #1;
        tiv[0] = 0;
        lat = 0;
        while (!ovl[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", lat, 4);
        ta[0] = 8'h11; tbv[0] = 8'h22; tsub[0] = 0; tiv[0] = 1;
        for (int c = 0; c < 5; c++) begin
            check("bp out_valid", int'(ovl[0]), 1);
            check("bp in_ready", int'(ir[0]), 0);
            check("bp sum", gsum(0), es);
            check("bp overflow", int'(ovf[0]), eo);
            @(posedge clk); #1;
        end
        tor[0] = 1;
        @(posedge clk); #1;
        tor[0] = 0;
        check("bp release out_valid", int'(ovl[0]), 0);
        check("bp release in_ready", int'(ir[0]), 1);
        tiv[0] = 0;

        tor[0] = 1; tiv[0] = 1; ta[0] = 8'h21; tbv[0] = 8'h43; tsub[0] = 0;
        for (int c = 0; c < 20; c++) begin
            if (ir[0]) acc_t.push_back(c);
            @(posedge clk); #1;
        end
        tiv[0] = 0;
        repeat (8) @(posedge clk);
        #1;
        tor[0] = 0;
        check("period accepts", int'(acc_t.size() >= 3), 1);
        check("period 1", acc_t.size() >= 2 ? acc_t[1] - acc_t[0] : -1, 6);
        check("period 2", acc_t.size() >= 3 ? acc_t[2] - acc_t[1] : -1, 6);
        check("period sum", gsum(0), 'h064);

        ta[0] = 8'h12; tbv[0] = 8'h34; tcin[0] = 0; tsub[0] = 0; tiv[0] = 1;
        @(posedge clk); #1;
        tiv[0] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst run out_valid", int'(ovl[0]), 0);
        check("rst run in_ready", int'(ir[0]), 1);
        check("rst run sum", gsum(0), 0);
        op(0, 'h33, 'h44, 0, 0, "after rst 33+44");

        for (int k = 0; k < 40; k++)
            op(0, int'($urandom_range(255)), int'($urandom_range(255)),
               int'($urandom_range(1)), int'($urandom_range(1)), "random w8");

        for (int i = 1; i < 3; i++)
            for (int v = 0; v < 256; v++)
                if (((v >> 3) & 7) < 8 && v < 128)
                    op(i, v & 7, (v >> 3) & 7, (v >> 6) & 1, (v >> 7) & 1, "exhaustive w3");
        for (int i = 1; i < 3; i++)
            for (int v = 0; v < 128; v++)
                op(i, v & 7, (v >> 3) & 7, (v >> 6) & 1, 1, "exhaustive w3 sub");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
